// File: rtl/top_test_pkg.sv
// Shared constants, address codes and controller state encoding for the spiking goodness core.
package top_test_pkg;

  localparam int N_NEUR_DEF  = 16;
  localparam int N_PIX_DEF   = 784;
  localparam int T_STEPS_DEF = 8;
  localparam int W_W_DEF     = 8;
  localparam int V_W_DEF     = 16;
  localparam int THRESH_DEF  = 64;
  localparam int W_INIT_DEF  = 1;

  localparam logic [11:0] TICK_CODE = 12'h4FF;
  localparam logic [1:0]  PIX_SEL   = 2'b00;

  typedef enum logic [2:0] {
    INIT, IDLE, SPIKE, TICK, GOOD, UPDATE, DONE, WAIT_REQ_LOW
  } state_t;

endpackage

// File: rtl/weight_ram.sv
// Single-port weight store; read data valid one cycle after the address (read-first).
// No reset: contents are rewritten by the controller after every reset.
module weight_ram #(
  parameter int DEPTH = 12544,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/top_test_core.sv
// Event-driven spiking layer: integrates pixel spikes, fires on ticks, scores goodness, trains weights.
// Latency: spike ~N_NEUR+2 cycles, tick up to 3*N_NEUR; AERIN_ACK held until AERIN_REQ drops.
module top_test_core
  import top_test_pkg::*;
#(
  parameter int N_NEUR  = N_NEUR_DEF,
  parameter int N_PIX   = N_PIX_DEF,
  parameter int T_STEPS = T_STEPS_DEF,
  parameter int W_W     = W_W_DEF,
  parameter int V_W     = V_W_DEF,
  parameter int THRESH  = THRESH_DEF,
  parameter int W_INIT  = W_INIT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] AERIN_ADDR,
  input  logic        AERIN_REQ,
  input  logic        IS_POS,
  input  logic        IS_TRAIN,
  output logic        AERIN_ACK,
  output logic [31:0] GOODNESS,
  output logic        PROCESS_DONE
);

  localparam int NW    = $clog2(N_NEUR);
  localparam int DEPTH = N_PIX * N_NEUR;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
  localparam logic signed [V_W-1:0] THR_V = V_W'(THRESH);
  localparam logic signed [V_W-1:0] V_MAX = {1'b0, {(V_W-1){1'b1}}};
  localparam logic signed [V_W-1:0] V_MIN = {1'b1, {(V_W-1){1'b0}}};
  localparam logic [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
  localparam logic [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};

  state_t state, state_d;

  logic signed [V_W-1:0] v_mem [N_NEUR];
  logic [3:0]            c_mem [N_NEUR];
  logic [N_PIX-1:0]      pre_flag;
  logic [N_NEUR-1:0]     post_flag;
  logic [TW-1:0]         tick_cnt;
  logic [9:0]            pix_q;
  logic [AW-1:0]         cnt;
  logic [NW-1:0]         nidx;
  logic                  upd_ph, pos_q;
  logic [31:0]           good_acc;

  // AEROUT_ADDR doubles as the neuron scan index while a tick is processed
  logic [9:0] AEROUT_ADDR;
  logic       AEROUT_REQ, AEROUT_ACK;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W_W-1:0] ram_wdata, ram_rdata, w_upd;

  logic [NW-1:0] tick_n, spk_n;
  logic fire, tick_adv, tick_last, upd_rmw, upd_step, upd_pix_end;

  function automatic logic [AW-1:0] pix_addr(input logic [9:0] p, input logic [NW-1:0] n);
    return AW'(32'(p) * N_NEUR + 32'(n));
  endfunction

  function automatic logic signed [V_W-1:0] sat_add(input logic signed [V_W-1:0] v,
                                                    input logic [W_W-1:0] w);
    logic [V_W:0] s;
    s = {v[V_W-1], v} + {{(V_W+1-W_W){w[W_W-1]}}, w};
    if (s[V_W] != s[V_W-1]) return s[V_W] ? V_MIN : V_MAX;
    return s[V_W-1:0];
  endfunction

  function automatic logic [31:0] sq(input logic [3:0] c);
    return 32'(c) * 32'(c);
  endfunction

  assign tick_n      = AEROUT_ADDR[NW-1:0];
  assign spk_n       = cnt[NW-1:0];
  assign fire        = !AEROUT_REQ && (v_mem[tick_n] >= THR_V);
  assign tick_adv    = AEROUT_REQ ? AEROUT_ACK : !fire;
  assign tick_last   = (AEROUT_ADDR == 10'(N_NEUR-1));
  assign upd_rmw     = pre_flag[pix_q] && post_flag[nidx];
  assign upd_step    = !upd_rmw || upd_ph;
  assign upd_pix_end = !pre_flag[pix_q] || (upd_step && nidx == NW'(N_NEUR-1));
  assign w_upd = pos_q ? ((ram_rdata == W_MAX) ? ram_rdata : ram_rdata + W_W'(1))
                       : ((ram_rdata == W_MIN) ? ram_rdata : ram_rdata - W_W'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= INIT;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = W_W'(W_INIT);
        if (cnt == AW'(DEPTH-1)) state_d = IDLE;
      end
      IDLE: if (AERIN_REQ && !AERIN_ACK) begin
        if (AERIN_ADDR[11:10] == PIX_SEL && AERIN_ADDR[9:0] < 10'(N_PIX)) state_d = SPIKE;
        else if (AERIN_ADDR == TICK_CODE)                                 state_d = TICK;
        else                                                              state_d = WAIT_REQ_LOW;
      end
      SPIKE: begin
        ram_addr = pix_addr(pix_q, spk_n);
        if (cnt == AW'(N_NEUR)) state_d = WAIT_REQ_LOW;
      end
      TICK: if (tick_adv && tick_last)
        state_d = (tick_cnt == TW'(T_STEPS-1)) ? GOOD : WAIT_REQ_LOW;
      GOOD: if (cnt == AW'(N_NEUR-1)) state_d = IS_TRAIN ? UPDATE : DONE;
      UPDATE: begin
        ram_addr  = pix_addr(pix_q, nidx);
        ram_we    = upd_rmw && upd_ph;
        ram_wdata = w_upd;
        if (upd_pix_end && pix_q == 10'(N_PIX-1)) state_d = DONE;
      end
      DONE:         state_d = WAIT_REQ_LOW;
      WAIT_REQ_LOW: if (!AERIN_REQ) state_d = IDLE;
      default:      state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AERIN_ACK    <= 1'b0;
      PROCESS_DONE <= 1'b0;
      GOODNESS     <= '0;
      AEROUT_REQ   <= 1'b0;
      AEROUT_ACK   <= 1'b0;
      AEROUT_ADDR  <= '0;
      for (int i = 0; i < N_NEUR; i++) begin
        v_mem[i] <= '0;
        c_mem[i] <= '0;
      end
      pre_flag  <= '0;
      post_flag <= '0;
      tick_cnt  <= '0;
      pix_q     <= '0;
      cnt       <= '0;
      nidx      <= '0;
      upd_ph    <= 1'b0;
      pos_q     <= 1'b0;
      good_acc  <= '0;
    end else begin
      AERIN_ACK    <= (state_d == WAIT_REQ_LOW);
      PROCESS_DONE <= (state_d == DONE);
      AEROUT_ACK   <= AEROUT_REQ && !AEROUT_ACK;
      case (state)
        INIT: cnt <= (state_d == IDLE) ? '0 : cnt + AW'(1);
        IDLE: begin
          pix_q <= AERIN_ADDR[9:0];
          cnt   <= '0;
        end
        SPIKE: begin
          cnt <= cnt + AW'(1);
          if (cnt != '0) v_mem[spk_n - NW'(1)] <= sat_add(v_mem[spk_n - NW'(1)], ram_rdata);
          if (cnt == AW'(N_NEUR)) pre_flag[pix_q] <= 1'b1;
        end
        TICK: begin
          if (AEROUT_REQ && AEROUT_ACK) AEROUT_REQ <= 1'b0;
          if (fire) begin
            v_mem[tick_n]     <= '0;
            c_mem[tick_n]     <= (c_mem[tick_n] == 4'hF) ? 4'hF : c_mem[tick_n] + 4'd1;
            post_flag[tick_n] <= 1'b1;
            AEROUT_REQ        <= 1'b1;
          end
          if (tick_adv) begin
            if (tick_last) begin
              AEROUT_ADDR <= '0;
              tick_cnt    <= (tick_cnt == TW'(T_STEPS-1)) ? '0 : tick_cnt + TW'(1);
              cnt         <= '0;
              good_acc    <= '0;
            end else begin
              AEROUT_ADDR <= AEROUT_ADDR + 10'd1;
            end
          end
        end
        GOOD: begin
          good_acc <= good_acc + sq(c_mem[spk_n]);
          cnt      <= cnt + AW'(1);
          if (state_d != GOOD) begin
            GOODNESS <= good_acc + sq(c_mem[spk_n]);
            pix_q    <= '0;
            nidx     <= '0;
            upd_ph   <= 1'b0;
            pos_q    <= IS_POS;
          end
        end
        UPDATE: begin
          if (upd_pix_end) begin
            nidx   <= '0;
            upd_ph <= 1'b0;
            pix_q  <= pix_q + 10'd1;
          end else if (upd_step) begin
            nidx   <= nidx + NW'(1);
            upd_ph <= 1'b0;
          end else begin
            upd_ph <= 1'b1;
          end
        end
        DONE: begin
          for (int i = 0; i < N_NEUR; i++) begin
            v_mem[i] <= '0;
            c_mem[i] <= '0;
          end
          pre_flag  <= '0;
          post_flag <= '0;
        end
        default: ;
      endcase
    end
  end

  weight_ram #(.DEPTH(DEPTH), .AW(AW), .DW(W_W)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_top_test_core.sv
// Directed bench for top_test_core: event-level reference model plus a per-cycle compare process.
module tb_top_test_core;
  import top_test_pkg::*;

  localparam int NN  = 16;
  localparam int NP  = 784;
  localparam int TS  = 8;
  localparam int TCK = 'h4FF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [11:0] AERIN_ADDR = '0;
  logic        AERIN_REQ = 1'b0;
  logic        IS_POS = 1'b0;
  logic        IS_TRAIN = 1'b0;
  logic        AERIN_ACK;
  logic [31:0] GOODNESS;
  logic        PROCESS_DONE;

  top_test_core dut (
    .CLK          (CLK),
    .RST          (RST),
    .AERIN_ADDR   (AERIN_ADDR),
    .AERIN_REQ    (AERIN_REQ),
    .IS_POS       (IS_POS),
    .IS_TRAIN     (IS_TRAIN),
    .AERIN_ACK    (AERIN_ACK),
    .GOODNESS     (GOODNESS),
    .PROCESS_DONE (PROCESS_DONE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  int m_w [NP][NN];
  int m_v [NN];
  int m_c [NN];
  bit m_pre [NP];
  bit m_post [NN];
  int m_tick, exp_good, exp_done;
  int exp_aer [$];
  int aer_total = 0;
  int done_seen = 0;
  int acks, k, a0;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < NN; n++) begin m_v[n] = 0; m_c[n] = 0; m_post[n] = 0; end
    for (int p = 0; p < NP; p++) m_pre[p] = 0;
  endfunction

  function automatic void model_init();
    for (int p = 0; p < NP; p++) for (int n = 0; n < NN; n++) m_w[p][n] = 1;
    model_clear();
    m_tick = 0; exp_good = 0; exp_done = 0;
  endfunction

  // One whole address event, applied at the level of the behavioural rules
  function automatic void model_event(int addr);
    int s;
    if (addr < NP) begin
      for (int n = 0; n < NN; n++) begin
        s = m_v[n] + m_w[addr][n];
        m_v[n] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
      end
      m_pre[addr] = 1;
    end else if (addr == TCK) begin
      for (int n = 0; n < NN; n++) if (m_v[n] >= 64) begin
        m_v[n] = 0;
        m_c[n] = (m_c[n] < 15) ? m_c[n] + 1 : 15;
        m_post[n] = 1;
        exp_aer.push_back(n);
      end
      m_tick++;
      if (m_tick == TS) begin
        m_tick = 0;
        exp_good = 0;
        for (int n = 0; n < NN; n++) exp_good += m_c[n] * m_c[n];
        if (IS_TRAIN)
          for (int p = 0; p < NP; p++) for (int n = 0; n < NN; n++)
            if (m_pre[p] && m_post[n])
              m_w[p][n] = IS_POS ? ((m_w[p][n] < 127) ? m_w[p][n] + 1 : 127)
                                 : ((m_w[p][n] > -128) ? m_w[p][n] - 1 : -128);
        exp_done++;
        model_clear();
      end
    end
  endfunction

  task automatic monitor();
    bit prev_ack, prev_aer, prev_done;
    prev_ack = 0; prev_aer = 0; prev_done = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_ack = 0; prev_aer = 0; prev_done = 0;
        continue;
      end
      if (dut.AEROUT_REQ && !prev_aer) begin
        aer_total++;
        if (exp_aer.size() == 0) check("aerout_unexpected", dut.AEROUT_ADDR, -1);
        else                     check("aerout_addr", dut.AEROUT_ADDR, exp_aer.pop_front());
      end
      if (PROCESS_DONE) begin
        done_seen++;
        check("done_width", prev_done, 0);
      end
      if (AERIN_ACK && !prev_ack) begin
        check("goodness", GOODNESS, exp_good);
        check("done_count", done_seen, exp_done);
        check("aerout_pending", exp_aer.size(), 0);
      end
      prev_ack  = AERIN_ACK;
      prev_aer  = dut.AEROUT_REQ;
      prev_done = PROCESS_DONE;
    end
  endtask

  task automatic send(input int addr);
    int w;
    @(negedge CLK);
    AERIN_ADDR = 12'(addr);
    AERIN_REQ  = 1'b1;
    model_event(addr);
    w = 0;
    while (!AERIN_ACK && w < 5000) begin @(negedge CLK); w++; end
    check("ack_seen", AERIN_ACK, 1);
    AERIN_REQ = 1'b0;
    w = 0;
    while (AERIN_ACK && w < 10) begin @(negedge CLK); w++; end
    check("ack_drop_latency", w, 1);
  endtask

  task automatic run_ticks(input int base, input int nsp, input int nt);
    for (int t = 0; t < nt; t++) begin
      for (int i = 0; i < nsp; i++) send(base + i);
      send(TCK);
    end
  endtask

  initial begin
    fork monitor(); join_none
    model_init();
    repeat (3) @(negedge CLK);
    check("rst_ack", AERIN_ACK, 0);
    check("rst_done", PROCESS_DONE, 0);
    check("rst_goodness", GOODNESS, 0);
    check("rst_aerout_req", dut.AEROUT_REQ, 0);
    RST = 1'b1;

    // request held from the start of INIT: no ACK until the weight fill finishes
    AERIN_ADDR = 12'hC00;
    AERIN_REQ  = 1'b1;
    acks = 0;
    repeat (12000) begin @(negedge CLK); if (AERIN_ACK) acks++; end
    check("ack_during_init", acks, 0);
    k = 0;
    while (!AERIN_ACK && k < 2000) begin @(negedge CLK); k++; end
    check("ack_after_init", AERIN_ACK, 1);
    AERIN_REQ = 1'b0;
    k = 0;
    while (AERIN_ACK && k < 10) begin @(negedge CLK); k++; end
    check("init_ack_release", AERIN_ACK, 0);

    IS_TRAIN = 1'b0; IS_POS = 1'b1;
    a0 = aer_total;
    run_ticks(0, 64, 1);
    check("tick1_aerout_count", aer_total - a0, 16);
    check("tick1_no_done", done_seen, 0);
    run_ticks(0, 64, 7);
    check("s1_done", done_seen, 1);
    check("s1_goodness", GOODNESS, 1024);

    a0 = aer_total;
    run_ticks(0, 0, 8);
    check("s2_goodness", GOODNESS, 0);
    check("s2_aerout_count", aer_total - a0, 0);
    check("s2_done", done_seen, 2);

    IS_TRAIN = 1'b1; IS_POS = 1'b1;
    run_ticks(0, 64, 8);
    check("s3_goodness", GOODNESS, 1024);
    check("w_p0_n0", dut.u_ram.mem[0], 2);
    check("w_p63_n15", dut.u_ram.mem[63*16+15], 2);
    check("w_p64_n0", dut.u_ram.mem[64*16], 1);
    check("model_w_p0", m_w[0][0], 2);

    IS_TRAIN = 1'b0;
    for (int i = 0; i < 64; i++) send(i);
    check("v0_128", dut.v_mem[0], 128);
    check("v15_128", dut.v_mem[15], 128);
    send(TCK);
    run_ticks(0, 64, 7);
    check("s4_goodness", GOODNESS, 1024);
    check("w_p10_n5_kept", dut.u_ram.mem[10*16+5], 2);

    IS_TRAIN = 1'b1; IS_POS = 1'b0;
    run_ticks(100, 64, 8);
    check("s5_goodness", GOODNESS, 1024);
    check("w_p100_n3", dut.u_ram.mem[100*16+3], 0);
    check("model_w_p100", m_w[100][3], 0);

    IS_TRAIN = 1'b0;
    run_ticks(100, 64, 8);
    check("s6_goodness", GOODNESS, 0);

    for (int i = 0; i < 10; i++) send(i);
    check("v_partial", dut.v_mem[0], 20);
    send(800);
    check("v_after_800", dut.v_mem[0], 20);
    check("pre_after_800", $countones(dut.pre_flag), 10);
    check("good_after_800", GOODNESS, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
